vreg_stream_ctrl: RTL and testbench
===================================

# vreg_stream_ctrl

Vector load/store streaming controller; the initiator that drives the vector register file's sequential (serial) port. It moves one 16-element × 16-bit vector between a word-addressed memory and a selected vector register. A 16-entry internal buffer decouples the stallable memory handshake from the register file's non-stallable 16-cycle serial burst. It sits between the vector issue logic (Start/Op/Busy/Done) and the register file plus data memory.

## Interface
- RD_LAT, 2, cycles from the first cycle RegRD_s is high to the capture edge of element 0 on RegDataIn_s
- Clk  in  1  single system clock, all state on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- Start  in  1  request pulse; accepted only in IDLE
- Op  in  1  0 = load (memory → register), 1 = store (register → memory)
- VAddr  in  3  target vector register, captured at Start
- MemBase  in  16  base word address, captured at Start
- Stride  in  16  element stride, captured at Start (present only with VLS_STRIDE_EN)
- Busy  out  1  high while an operation is in progress
- Done  out  1  one-cycle completion pulse
- MemReq  out  1  memory request valid
- MemWe  out  1  1 = write, 0 = read; valid with MemReq
- MemAddr  out  16  word address; valid with MemReq
- MemWData  out  16  write data; valid with MemReq && MemWe
- MemAck  in  1  memory accepts/completes the request on this edge
- MemRData  in  16  read data; valid when MemAck
- RegAddr  out  3  register select to register file
- RegWR_s  out  1  serial write strobe to register file
- RegRD_s  out  1  serial read strobe to register file
- RegDataOut_s  out  16  element to register file serial input
- RegDataIn_s  in  16  element from register file serial output

## Operation
- States: IDLE, MEM_RD, REG_WR, REG_RD, MEM_WR, DONE. Element counter k: 4 bits (RD_LAT extension in REG_RD).
- IDLE: on Start, capture VAddr/MemBase/Op (and Stride); k=0; go to MEM_RD if Op=0, else REG_RD.
- MEM_RD: MemReq=1, MemWe=0, MemAddr=addr(k). On MemReq&&MemAck edge: buf[k]←MemRData; k=15 → REG_WR (k=0), else k+1. MemAck=0 holds the request unchanged indefinitely.
- REG_WR: exactly 16 consecutive cycles, RegWR_s=1, RegDataOut_s=buf[k] in cycle k; then DONE.
- REG_RD: RegRD_s=1 for exactly 16 consecutive cycles; element j captured into buf[j] at edge j+RD_LAT; state lasts 16+RD_LAT cycles, then MEM_WR (k=0).
- MEM_WR: MemReq=1, MemWe=1, MemAddr=addr(k), MemWData=buf[k]; advance on MemAck as in MEM_RD; after k=15 → DONE.
- DONE: Done=1 for one cycle → IDLE.
- addr(k) = MemBase + k×stride, modulo 2^16 (wrap, no error).
- RegAddr = captured VAddr for the whole operation; RegWR_s and RegRD_s never high together; never high outside REG_WR/REG_RD.

## Timing
- Reset values: Busy, Done, MemReq, MemWe, RegWR_s, RegRD_s = 0; MemAddr, MemWData, RegDataOut_s = 0; RegAddr = 0; state IDLE. Buffer not reset.
- Busy rises the cycle after Start is sampled; falls together with Done (Busy=0 in the DONE cycle).
- Start while Busy or in DONE: ignored, no queueing.
- Load latency with MemAck always 1: 16 (MEM_RD) + 16 (REG_WR) + 1 (DONE) = 33 cycles Start-edge to Done.
- Store latency with MemAck always 1: 16+RD_LAT + 16 + 1 = 35 cycles (RD_LAT=2).
- Register bursts are never paused; memory stalls only stretch MEM_RD/MEM_WR.
- Reset mid-operation (including mid-burst): outputs drop to reset values asynchronously; no Done; register file contents partially written are not restored.
- All outputs registered.

## Configuration
- VLS_STRIDE_EN defined: Stride input present, captured at Start; stride = Stride (0 legal: all accesses to MemBase).
- Undefined: no Stride port; stride fixed at 1.

## Test plan
- Load, MemAck tied 1, MemBase=0x0100, memory[0x100+i]=0xA000+i, VAddr=3 → RegWR_s high 16 cycles, RegDataOut_s=0xA000..0xA00F, RegAddr=3, Done at cycle 33.
- Load with MemAck low 2 of every 3 cycles → same 16 register values, REG_WR still 16 contiguous cycles, Done delayed by stalls only.
- Store, register 5 holding 0xB000+i, RegDataIn_s modelled with RD_LAT=2 → MemWData=0xB000..0xB00F at MemAddr MemBase..+15, Done at cycle 35.
- Start re-asserted every cycle during a load → exactly one operation, one Done pulse.
- Rst_n low at REG_WR cycle 7 → RegWR_s, Busy, MemReq 0 immediately; no Done; next Start runs normally.
- VLS_STRIDE_EN, MemBase=0xFFF8, Stride=2 → MemAddr 0xFFF8,0xFFFA,…,0xFFFE,0x0000,…,0x0016 (wraps).

Source files
------------

// File: rtl/vreg_stream_ctrl.sv
// Purpose: moves one 16 x 16-bit vector between word-addressed memory and a vector register through a 16-entry buffer.
// Latency: Start edge to Done = 33 cycles (load) / 16+RD_LAT+17 cycles (store) with MemAck held high.
// Backpressure: MemAck low holds the memory request and stretches only MEM_RD/MEM_WR; register bursts never pause.
//
// Ports:
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   Start, Op, VAddr, MemBase       request pulse, 0=load/1=store, register select, base word address
//   Stride                          element stride (only when VLS_STRIDE_EN is defined; otherwise stride is 1)
//   Busy, Done                      operation in progress, one-cycle completion pulse
//   MemReq/MemWe/MemAddr/MemWData   memory request channel; MemAck/MemRData completion and read data
//   RegAddr/RegWR_s/RegRD_s         register file serial port strobes and select
//   RegDataOut_s, RegDataIn_s       serial element to / from the register file
// Build option: VLS_STRIDE_EN adds the Stride input.
module vreg_stream_ctrl #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Op,
  input  logic [2:0]  VAddr,
  input  logic [15:0] MemBase,
`ifdef VLS_STRIDE_EN
  input  logic [15:0] Stride,
`endif
  output logic        Busy,
  output logic        Done,
  output logic        MemReq,
  output logic        MemWe,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  input  logic        MemAck,
  input  logic [15:0] MemRData,
  output logic [2:0]  RegAddr,
  output logic        RegWR_s,
  output logic        RegRD_s,
  output logic [15:0] RegDataOut_s,
  input  logic [15:0] RegDataIn_s
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_RD,
    S_REG_WR,
    S_REG_RD,
    S_MEM_WR,
    S_DONE
  } state_t;

  // REG_RD cycle indices: element j arrives in the cycle ending RD_LAT edges after
  // the burst starts, i.e. REG_RD cycle j+RD_LAT-1; the state ends after cycle RD_LAT+15.
  localparam logic [4:0] CAP_FIRST = 5'(RD_LAT - 1);
  localparam logic [4:0] CAP_LAST  = 5'(RD_LAT + 14);
  localparam logic [4:0] RD_END    = 5'(RD_LAT + 15);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] step;

  logic [15:0] vbuf [16];
  logic        buf_we;
  logic [3:0]  buf_wi;
  logic [15:0] buf_wd;
  logic [15:0] buf_rd;

  logic [15:0] addr_d;
  logic [15:0] wdata_d;
  logic [15:0] dout_d;
  logic [2:0]  vaddr_d;
  logic        busy_d, done_d, req_d, we_d, wr_d, rd_d;

`ifdef VLS_STRIDE_EN
  logic [15:0] stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = 16'd1;
`endif

  // The buffer entry needed next cycle is selected by the next element index,
  // so the registered data outputs line up with their strobes.
  assign buf_rd = vbuf[cnt_d[3:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = MemAddr;
    vaddr_d = RegAddr;
    buf_we  = 1'b0;
    buf_wi  = cnt_q[3:0];
    buf_wd  = MemRData;
`ifdef VLS_STRIDE_EN
    stride_d = stride_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          vaddr_d = VAddr;
          addr_d  = MemBase;
          cnt_d   = 5'd0;
`ifdef VLS_STRIDE_EN
          stride_d = Stride;
`endif
          state_d = Op ? S_REG_RD : S_MEM_RD;
        end
      end

      S_MEM_RD: begin
        if (MemAck) begin
          buf_we = 1'b1;
          buf_wd = MemRData;
          addr_d = MemAddr + step;
          if (cnt_q == 5'd15) begin
            cnt_d   = 5'd0;
            state_d = S_REG_WR;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_REG_WR: begin
        if (cnt_q == 5'd15) begin
          cnt_d   = 5'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_REG_RD: begin
        if (cnt_q >= CAP_FIRST && cnt_q <= CAP_LAST) begin
          buf_we = 1'b1;
          buf_wi = 4'(cnt_q - CAP_FIRST);
          buf_wd = RegDataIn_s;
        end
        if (cnt_q == RD_END) begin
          cnt_d   = 5'd0;
          state_d = S_MEM_WR;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_MEM_WR: begin
        if (MemAck) begin
          addr_d = MemAddr + step;
          if (cnt_q == 5'd15) begin
            cnt_d   = 5'd0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    busy_d  = (state_d == S_MEM_RD) || (state_d == S_REG_WR) ||
              (state_d == S_REG_RD) || (state_d == S_MEM_WR);
    done_d  = (state_d == S_DONE);
    req_d   = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    we_d    = (state_d == S_MEM_WR);
    wr_d    = (state_d == S_REG_WR);
    rd_d    = (state_d == S_REG_RD) && (cnt_d < 5'd16);
    wdata_d = (state_d == S_MEM_WR) ? buf_rd : MemWData;
    dout_d  = (state_d == S_REG_WR) ? buf_rd : RegDataOut_s;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      MemReq       <= 1'b0;
      MemWe        <= 1'b0;
      MemAddr      <= 16'd0;
      MemWData     <= 16'd0;
      RegAddr      <= 3'd0;
      RegWR_s      <= 1'b0;
      RegRD_s      <= 1'b0;
      RegDataOut_s <= 16'd0;
`ifdef VLS_STRIDE_EN
      stride_q     <= 16'd1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      Busy         <= busy_d;
      Done         <= done_d;
      MemReq       <= req_d;
      MemWe        <= we_d;
      MemAddr      <= addr_d;
      MemWData     <= wdata_d;
      RegAddr      <= vaddr_d;
      RegWR_s      <= wr_d;
      RegRD_s      <= rd_d;
      RegDataOut_s <= dout_d;
`ifdef VLS_STRIDE_EN
      stride_q     <= stride_d;
`endif
    end
  end

  // Element buffer is pure storage: every entry is written before it is read
  // within an operation, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (buf_we) begin
      vbuf[buf_wi] <= buf_wd;
    end
  end

endmodule

// File: tb/tb_vreg_stream_ctrl.sv
`timescale 1ns/1ps
module tb_vreg_stream_ctrl;
  localparam int RD_LAT = 2;

  logic        Clk = 1'b0;
  logic        Rst_n, Start, Op;
  logic [2:0]  VAddr;
  logic [15:0] MemBase, Stride;
  logic        Busy, Done, MemReq, MemWe, MemAck;
  logic [15:0] MemAddr, MemWData, MemRData;
  logic [2:0]  RegAddr;
  logic        RegWR_s, RegRD_s;
  logic [15:0] RegDataOut_s, RegDataIn_s;

  always #5 Clk = ~Clk;

  vreg_stream_ctrl #(.RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .VAddr(VAddr), .MemBase(MemBase),
`ifdef VLS_STRIDE_EN
    .Stride(Stride),
`endif
    .Busy(Busy), .Done(Done), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData), .RegAddr(RegAddr),
    .RegWR_s(RegWR_s), .RegRD_s(RegRD_s), .RegDataOut_s(RegDataOut_s), .RegDataIn_s(RegDataIn_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- memory and register file models ----------------
  logic [15:0] mem  [0:65535];
  logic [15:0] regs [0:7][0:15];
  int ack_mode = 0;
  int cyc = 0;

  always @(posedge Clk) begin
    cyc++;
    #1;
    case (ack_mode)
      0:       MemAck = 1'b1;
      1:       MemAck = (cyc % 3 == 0);
      default: MemAck = ($urandom_range(0, 3) != 0);
    endcase
    MemRData = MemAck ? mem[MemAddr] : 16'($urandom);
  end

  always @(negedge Clk) begin
    if (Rst_n && MemReq && MemWe && MemAck) mem[MemAddr] = MemWData;
  end

  // Register file: strobe seen in cycle n, element presented in cycle n+1.
  logic       rd_seen = 1'b0;
  logic [2:0] ra_seen = 3'd0;
  int         rptr = 0;
  always @(negedge Clk) begin
    rd_seen = RegRD_s;
    ra_seen = RegAddr;
  end
  always @(posedge Clk) begin
    #1;
    if (rd_seen && rptr < 16) begin
      RegDataIn_s = regs[ra_seen][rptr];
      rptr++;
    end else begin
      RegDataIn_s = 16'($urandom);
      if (!rd_seen) rptr = 0;
    end
  end

  // ---------------- behavioural reference model + compare ----------------
  int phase = 0;
  int lat = 0, mem_idx = 0, wr_idx = 0, rd_idx = 0, gap = 0, stall_cnt = 0;
  int done_lat = 0, done_cnt = 0;
  logic        m_op;
  logic [2:0]  m_va;
  logic [15:0] m_base, m_stride;
  logic [15:0] exp_vals [16];
  logic [15:0] wr_log [$];
  logic [15:0] addr_log [$];
  bit e_req, e_wr, e_rd, e_gap;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      phase = 0;
      chk("rst_busy", Busy, 0);       chk("rst_done", Done, 0);
      chk("rst_req", MemReq, 0);      chk("rst_we", MemWe, 0);
      chk("rst_regwr", RegWR_s, 0);   chk("rst_regrd", RegRD_s, 0);
      chk("rst_addr", MemAddr, 0);    chk("rst_wdata", MemWData, 0);
      chk("rst_dout", RegDataOut_s, 0); chk("rst_regaddr", RegAddr, 0);
    end else if (phase == 0) begin
      chk("idle_busy", Busy, 0);  chk("idle_done", Done, 0);
      chk("idle_req", MemReq, 0); chk("idle_regwr", RegWR_s, 0); chk("idle_regrd", RegRD_s, 0);
      if (Start) begin
        m_op = Op; m_va = VAddr; m_base = MemBase;
`ifdef VLS_STRIDE_EN
        m_stride = Stride;
`else
        m_stride = 16'd1;
`endif
        for (int i = 0; i < 16; i++) exp_vals[i] = mem[16'(m_base + 16'(i) * m_stride)];
        mem_idx = 0; wr_idx = 0; rd_idx = 0; gap = 0; stall_cnt = 0; lat = 0;
        wr_log.delete(); addr_log.delete();
        phase = 1;
      end
    end else if (phase == 1) begin
      lat++;
      if (!m_op) begin
        e_req = (mem_idx < 16);
        e_wr  = (mem_idx == 16) && (wr_idx < 16);
        e_rd  = 1'b0;
        e_gap = 1'b0;
      end else begin
        e_rd  = (rd_idx < 16);
        e_gap = (rd_idx == 16) && (gap < RD_LAT);
        e_req = (rd_idx == 16) && (gap == RD_LAT) && (mem_idx < 16);
        e_wr  = 1'b0;
      end
      chk("busy", Busy, 1);
      chk("done_early", Done, 0);
      chk("memreq", MemReq, e_req);
      chk("regwr", RegWR_s, e_wr);
      chk("regrd", RegRD_s, e_rd);
      chk("regaddr", RegAddr, m_va);
      if (e_req && MemReq) begin
        chk("memwe", MemWe, m_op);
        chk("memaddr", MemAddr, 16'(m_base + 16'(mem_idx) * m_stride));
        if (m_op) chk("memwdata", MemWData, regs[m_va][mem_idx]);
        if (MemAck) begin
          addr_log.push_back(MemAddr);
          mem_idx++;
        end else begin
          stall_cnt++;
        end
      end
      if (e_wr && RegWR_s) begin
        chk("regdout", RegDataOut_s, exp_vals[wr_idx]);
        wr_log.push_back(RegDataOut_s);
      end
      if (e_wr) wr_idx++;
      if (e_rd) rd_idx++;
      else if (e_gap) gap++;
      if ((!m_op && wr_idx == 16) || (m_op && mem_idx == 16)) phase = 2;
    end else begin
      lat++;
      chk("done", Done, 1);      chk("done_busy", Busy, 0);
      chk("done_req", MemReq, 0); chk("done_regwr", RegWR_s, 0); chk("done_regrd", RegRD_s, 0);
      done_lat = lat;
      done_cnt++;
      phase = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic op, input logic [2:0] va, input logic [15:0] base,
                          input logic [15:0] str);
    @(posedge Clk); #1;
    Start = 1'b1; Op = op; VAddr = va; MemBase = base; Stride = str;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge Clk); #1;
      if (Done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
  endtask

  initial begin
    int dc;
    bit seen;
    Rst_n = 1'b0; Start = 1'b0; Op = 1'b0; VAddr = 3'd0; MemBase = 16'd0; Stride = 16'd1;
    MemAck = 1'b0; MemRData = 16'd0; RegDataIn_s = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < 8; r++) for (int i = 0; i < 16; i++) regs[r][i] = 16'($urandom);

    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy", Busy, 0); chk("reset_memaddr", MemAddr, 0); chk("reset_regaddr", RegAddr, 0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Load: memory[0x100+i] = 0xA000+i into register 3
    for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'(16'hA000 + i);
    ack_mode = 0;
    start_op(1'b0, 3'd3, 16'h0100, 16'd1);
    wait_done(200);
    chk("load_latency", done_lat, 33);
    chk("load_count", wr_log.size(), 16);
    for (int i = 0; i < 16; i++) chk("load_value", wr_log[i], 16'hA000 + i);
    chk("load_regaddr", RegAddr, 3);

    // Same load with MemAck low two cycles out of three
    ack_mode = 1;
    start_op(1'b0, 3'd3, 16'h0100, 16'd1);
    wait_done(500);
    chk("stall_latency", done_lat, 33 + stall_cnt);
    chk("stall_seen", stall_cnt >= 30, 1);
    for (int i = 0; i < 16; i++) chk("stall_value", wr_log[i], 16'hA000 + i);

    // Store: register 5 holds 0xB000+i, written to 0x0200..0x020F
    ack_mode = 0;
    for (int i = 0; i < 16; i++) regs[5][i] = 16'(16'hB000 + i);
    start_op(1'b1, 3'd5, 16'h0200, 16'd1);
    wait_done(200);
    chk("store_latency", done_lat, 35);
    for (int i = 0; i < 16; i++) begin
      chk("store_addr", addr_log[i], 16'h0200 + i);
      chk("store_mem", mem[16'h0200 + i], 16'hB000 + i);
    end

    // Start held high through a whole load, including the DONE cycle
    dc = done_cnt;
    @(posedge Clk); #1;
    Start = 1'b1; Op = 1'b0; VAddr = 3'd1; MemBase = 16'h0300; Stride = 16'd1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge Clk); #1;
      if (Done) seen = 1'b1;
    end
    chk("held_done_seen", seen, 1);
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("held_one_done", done_cnt - dc, 1);
    chk("held_idle", Busy, 0);

    // Reset in REG_WR cycle 7
    start_op(1'b0, 3'd2, 16'h0400, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge Clk); #1;
      if (RegWR_s) seen = 1'b1;
    end
    chk("regwr_seen", seen, 1);
    repeat (7) @(posedge Clk);
    #1;
    dc = done_cnt;
    Rst_n = 1'b0;
    #1;
    chk("midrst_regwr", RegWR_s, 0); chk("midrst_busy", Busy, 0);
    chk("midrst_req", MemReq, 0);    chk("midrst_done", Done, 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("midrst_no_done", done_cnt, dc);
    start_op(1'b0, 3'd2, 16'h0400, 16'd1);
    wait_done(200);
    chk("after_rst_latency", done_lat, 33);

`ifdef VLS_STRIDE_EN
    start_op(1'b0, 3'd1, 16'hFFF8, 16'd2);
    wait_done(200);
    for (int i = 0; i < 16; i++) chk("stride_addr", addr_log[i], 16'(16'hFFF8 + 2 * i));
    chk("stride_wrap0", addr_log[4], 16'h0000);
    chk("stride_last", addr_log[15], 16'h0016);
`endif

    // Randomised traffic: random Start pulses (many while busy), random stalls
    ack_mode = 2;
    dc = done_cnt;
    repeat (3000) begin
      @(posedge Clk); #1;
      Start   = ($urandom_range(0, 5) == 0);
      Op      = 1'($urandom);
      VAddr   = 3'($urandom);
      MemBase = 16'($urandom);
      Stride  = 16'($urandom_range(0, 3));
    end
    Start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge Clk); #1;
      if (!Busy && !Done && phase == 0) seen = 1'b1;
    end
    chk("random_drain", seen, 1);
    chk("random_ops", done_cnt - dc > 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
